// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage. Runs loads/stores as byte-serial accesses on an 8-bit RAM port.
// Latency: non-memory ops write back next cycle; store = nbytes cycles; load write-back nbytes+2 cycles after accept.
// Backpressure: stall_req holds EX/MEM (stall bus bit 3 and below) while bytes remain to be moved.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   op_in[2:0]      funct3 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   status_in       000 nop, 001 reg op, 010 mem write, 011 mem read, 100 branch, 101 jal/jalr
//   mem_address_in  byte address of the access (no alignment required)
//   target_data_in  ALU result / link value / store data
//   reg_address_in  destination register
//   mem_din         RAM read byte, valid the cycle after its address
//   mem_a/mem_wr/mem_dout  registered RAM address, write strobe and write byte
//   stall_req       combinational stall request towards EX/MEM
//   wb_we/wb_addr/wb_data  registered write-back packet (wb_we is a one-cycle pulse)
//   misalign_err    one-cycle pulse for a dropped misaligned access
//
// Build option: define MEM_MISALIGN_TRAP_EN to drop misaligned H/W accesses and pulse misalign_err;
// otherwise misaligned accesses run bytewise and misalign_err is tied low.
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op_in,
  input  logic [2:0]        status_in,
  input  logic [ADDR_W-1:0] mem_address_in,
  input  logic [DATA_W-1:0] target_data_in,
  input  logic [4:0]        reg_address_in,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  output logic              stall_req,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign_err
);

  typedef enum logic [1:0] {IDLE, STORE, LOAD_ADDR, LOAD_WAIT} state_t;

  localparam logic [2:0] ST_REG = 3'b001;
  localparam logic [2:0] ST_WR  = 3'b010;
  localparam logic [2:0] ST_RD  = 3'b011;
  localparam logic [2:0] ST_JAL = 3'b101;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [1:0]        idx, idx_n;      // byte index currently presented on the RAM port
  logic [1:0]        rx, rx_n;        // next load byte lane to fill
  logic [1:0]        last, last_n;    // index of the final byte (nbytes-1)
  logic [1:0]        width, width_n;
  logic              uns, uns_n;
  logic [4:0]        rd, rd_n;
  logic [DATA_W-1:0] data_q, data_n;  // store data for stores, bytes gathered so far for loads
  logic [ADDR_W-1:0] mem_a_n;
  logic              mem_wr_n;
  logic [7:0]        mem_dout_n;
  logic              wb_we_n;
  logic [4:0]        wb_addr_n;
  logic [DATA_W-1:0] wb_data_n;
  logic [1:0]        idx_inc;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] ext;
  logic              drop;
  logic              unused_op;

  assign unused_op = ^op_in[5:3];

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (op_in[1:0] == 2'b01) ? mem_address_in[0]
                                            : ((op_in[1:0] != 2'b00) && (mem_address_in[1:0] != 2'b00));
  assign drop = (state == IDLE) && ((status_in == ST_WR) || (status_in == ST_RD)) && misaligned;

  always_ff @(posedge clk) begin
    if (rst) misalign_err <= 1'b0;
    else     misalign_err <= drop;
  end
`else
  assign drop         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // The store is not finished until its last byte is on the port; a load also stalls
  // through its last address cycle, releasing EX/MEM during the final data cycle.
  assign stall_req = ((state == STORE) && (idx != last)) || (state == LOAD_ADDR);

  // Gathered load word with the byte arriving this cycle dropped into its lane.
  always_comb begin
    merged = data_q;
    merged[{rx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    case (width)
      2'b00:   ext = uns ? {24'd0, merged[7:0]}  : {{24{merged[7]}}, merged[7:0]};
      2'b01:   ext = uns ? {16'd0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
      default: ext = merged;
    endcase
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    rx_n       = rx;
    last_n     = last;
    width_n    = width;
    uns_n      = uns;
    rd_n       = rd;
    data_n     = data_q;
    mem_a_n    = mem_a;
    mem_wr_n   = 1'b0;
    mem_dout_n = mem_dout;
    wb_we_n    = 1'b0;
    wb_addr_n  = wb_addr;
    wb_data_n  = wb_data;
    idx_inc    = idx + 2'd1;

    case (state)
      IDLE: begin
        idx_n   = 2'd0;
        rx_n    = 2'd0;
        width_n = op_in[1:0];
        uns_n   = op_in[2];
        rd_n    = reg_address_in;
        last_n  = (op_in[1:0] == 2'b00) ? 2'd0 : (op_in[1:0] == 2'b01) ? 2'd1 : 2'd3;
        if (!drop) begin
          case (status_in)
            ST_REG, ST_JAL: begin
              wb_we_n   = (reg_address_in != 5'd0);
              wb_addr_n = reg_address_in;
              wb_data_n = target_data_in;
            end
            ST_WR: begin
              state_n    = STORE;
              mem_a_n    = mem_address_in;
              mem_wr_n   = 1'b1;
              mem_dout_n = target_data_in[7:0];
              data_n     = target_data_in;
            end
            ST_RD: begin
              state_n = LOAD_ADDR;
              mem_a_n = mem_address_in;
              data_n  = '0;
            end
            default: ;
          endcase
        end
      end
      STORE: begin
        if (idx == last) begin
          state_n = IDLE;
        end else begin
          idx_n      = idx_inc;
          mem_a_n    = mem_a + ADDR_ONE;
          mem_wr_n   = 1'b1;
          mem_dout_n = data_q[{idx_inc, 3'b000} +: 8];
        end
      end
      LOAD_ADDR: begin
        // From the second address cycle on, the byte for the previous address is on mem_din.
        if (idx != 2'd0) begin
          data_n = merged;
          rx_n   = rx + 2'd1;
        end
        if (idx == last) begin
          state_n = LOAD_WAIT;
        end else begin
          idx_n   = idx_inc;
          mem_a_n = mem_a + ADDR_ONE;
        end
      end
      LOAD_WAIT: begin
        state_n   = IDLE;
        wb_we_n   = (rd != 5'd0);
        wb_addr_n = rd;
        wb_data_n = ext;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      rx       <= 2'd0;
      last     <= 2'd0;
      width    <= 2'd0;
      uns      <= 1'b0;
      rd       <= 5'd0;
      data_q   <= '0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
      mem_dout <= 8'd0;
      wb_we    <= 1'b0;
      wb_addr  <= 5'd0;
      wb_data  <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      rx       <= rx_n;
      last     <= last_n;
      width    <= width_n;
      uns      <= uns_n;
      rd       <= rd_n;
      data_q   <= data_n;
      mem_a    <= mem_a_n;
      mem_wr   <= mem_wr_n;
      mem_dout <= mem_dout_n;
      wb_we    <= wb_we_n;
      wb_addr  <= wb_addr_n;
      wb_data  <= wb_data_n;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op_in = '0;
  logic [2:0]  status_in = '0;
  logic [31:0] mem_address_in = '0;
  logic [31:0] target_data_in = '0;
  logic [4:0]  reg_address_in = '0;
  logic [7:0]  mem_din = '0;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic        stall_req;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        misalign_err;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .op_in(op_in), .status_in(status_in),
    .mem_address_in(mem_address_in), .target_data_in(target_data_in),
    .reg_address_in(reg_address_in), .mem_din(mem_din), .mem_a(mem_a),
    .mem_wr(mem_wr), .mem_dout(mem_dout), .stall_req(stall_req), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .misalign_err(misalign_err)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [2:0]  st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        pin_v;
    logic [31:0] pin;
    logic        ov_en;
    logic [31:0] ov_base;
    logic [31:0] ov_bytes;
  } ins_t;

  // RAM: fixed address pattern, with a few bytes overridden by directed tests.
  logic [7:0] ov [logic [31:0]];
  function automatic logic [7:0] ram_fn(input logic [31:0] a);
    if (ov.exists(a)) return ov[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction
  always @(posedge clk) mem_din <= ram_fn(mem_a);

  // Expected outputs per cycle.
  bit          e_rst [NCYC];
  bit          e_stall [NCYC];
  bit          e_wr [NCYC];
  bit          e_mchk [NCYC];
  logic [31:0] e_a [NCYC];
  logic [7:0]  e_dout [NCYC];
  bit          e_wbd [NCYC];
  bit          e_we [NCYC];
  logic [4:0]  e_wa [NCYC];
  logic [31:0] e_wd [NCYC];
  bit          e_err [NCYC];
  bit          p_vld [NCYC];
  logic [31:0] p_wd [NCYC];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [4:0]  last_wa = '0;
  logic [31:0] last_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      if (e_rst[cyc]) begin
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", {31'd0, misalign_err}, 32'd0);
        last_wa = '0;
        last_wd = '0;
      end else begin
        chk("stall_req", {31'd0, stall_req}, {31'd0, e_stall[cyc]});
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr[cyc]});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e_err[cyc]});
        if (e_mchk[cyc]) begin
          chk("mem_a", mem_a, e_a[cyc]);
          if (e_wr[cyc]) chk("mem_dout", {24'd0, mem_dout}, {24'd0, e_dout[cyc]});
        end
        if (e_wbd[cyc]) begin
          chk("wb_we", {31'd0, wb_we}, {31'd0, e_we[cyc]});
          chk("wb_addr", {27'd0, wb_addr}, {27'd0, e_wa[cyc]});
          chk("wb_data", wb_data, e_wd[cyc]);
          last_wa = e_wa[cyc];
          last_wd = e_wd[cyc];
        end else begin
          chk("wb_we_idle", {31'd0, wb_we}, 32'd0);
          chk("wb_addr_hold", {27'd0, wb_addr}, {27'd0, last_wa});
          chk("wb_data_hold", wb_data, last_wd);
        end
        if (p_vld[cyc]) chk("pin_wb_data", wb_data, p_wd[cyc]);
      end
    end
  end

  function automatic ins_t mk(input logic [5:0] op, input logic [2:0] st, input logic [31:0] addr,
                              input logic [31:0] data, input logic [4:0] rd);
    ins_t i;
    i = '0;
    i.op = op; i.st = st; i.addr = addr; i.data = data; i.rd = rd;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    logic [2:0] f3;
    int sel;
    i = '0;
    i.st = 3'($urandom_range(0, 5));
    sel = $urandom_range(0, 4);
    if (i.st == 3'b010) f3 = 3'(sel % 3);
    else f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
    i.op = {3'($urandom), f3};
    case ($urandom_range(0, 3))
      0:       i.addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      1:       i.addr = 32'($urandom_range(0, 63)) << 2;
      default: i.addr = $urandom;
    endcase
    i.data = $urandom;
    i.rd   = 5'($urandom_range(0, 31));
    return i;
  endfunction

  task automatic drive(input ins_t i);
    op_in = i.op; status_in = i.st; mem_address_in = i.addr;
    target_data_in = i.data; reg_address_in = i.rd;
  endtask

  task automatic garbage();
    op_in = 6'($urandom); status_in = 3'($urandom); mem_address_in = $urandom;
    target_data_in = $urandom; reg_address_in = 5'($urandom);
  endtask

  task automatic wb_exp(input int c, input bit we, input logic [4:0] wa, input logic [31:0] wd);
    e_wbd[c] = 1'b1; e_we[c] = we; e_wa[c] = wa; e_wd[c] = wd;
  endtask

  task automatic clear_after(input int c);
    for (int j = c + 1; j < c + 20 && j < NCYC; j++) begin
      e_rst[j] = 0; e_stall[j] = 0; e_wr[j] = 0; e_mchk[j] = 0;
      e_wbd[j] = 0; e_we[j] = 0; e_err[j] = 0; p_vld[j] = 0;
    end
  endtask

  // Expected behaviour of one instruction accepted in cycle t; nf = first cycle the stage is free again.
  task automatic schedule(input ins_t i, input int t, output int nf);
    int n;
    logic [31:0] v;
    n  = (i.op[1:0] == 2'b00) ? 1 : (i.op[1:0] == 2'b01) ? 2 : 4;
    nf = t + 1;
    if (i.ov_en)
      for (int k = 0; k < 4; k++) ov[i.ov_base + 32'(k)] = i.ov_bytes[8*k +: 8];
`ifdef MEM_MISALIGN_TRAP_EN
    if ((i.st == 3'b010 || i.st == 3'b011) &&
        ((n == 2 && i.addr[0]) || (n == 4 && i.addr[1:0] != 2'b00))) begin
      e_err[t+1] = 1'b1;
      return;
    end
`endif
    case (i.st)
      3'b001, 3'b101: begin
        wb_exp(t + 1, i.rd != 5'd0, i.rd, i.data);
        if (i.pin_v) begin p_vld[t+1] = 1'b1; p_wd[t+1] = i.pin; end
      end
      3'b010: begin
        for (int k = 0; k < n; k++) begin
          e_wr[t+1+k] = 1'b1; e_mchk[t+1+k] = 1'b1;
          e_a[t+1+k] = i.addr + 32'(k);
          e_dout[t+1+k] = i.data[8*k +: 8];
          e_stall[t+1+k] = (k < n - 1);
        end
        nf = t + n + 1;
      end
      3'b011: begin
        v = '0;
        for (int k = 0; k < n; k++) begin
          e_mchk[t+1+k] = 1'b1; e_a[t+1+k] = i.addr + 32'(k); e_stall[t+1+k] = 1'b1;
          v = v + (32'(ram_fn(i.addr + 32'(k))) << (8 * k));
        end
        if (n == 1) v = i.op[2] ? (v & 32'hFF)   : 32'($signed(v[7:0]));
        if (n == 2) v = i.op[2] ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
        wb_exp(t + n + 2, i.rd != 5'd0, i.rd, v);
        if (i.pin_v) begin p_vld[t+n+2] = 1'b1; p_wd[t+n+2] = i.pin; end
        nf = t + n + 2;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  ins_t prog[$];
  ins_t cur;
  int   next_free;

  initial begin
    cur = mk(6'b000010, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0);           prog.push_back(cur);
    cur = mk(6'b000000, 3'b011, 32'h200, 32'h0, 5'd5);
    cur.ov_en = 1; cur.ov_base = 32'h200; cur.ov_bytes = 32'h0304_0580;
    cur.pin_v = 1; cur.pin = 32'hFFFF_FF80;                                prog.push_back(cur);
    cur = mk(6'b000100, 3'b011, 32'h200, 32'h0, 5'd6);
    cur.pin_v = 1; cur.pin = 32'h0000_0080;                                prog.push_back(cur);
    cur = mk(6'b000010, 3'b011, 32'h1FF, 32'h0, 5'd7);
    cur.ov_en = 1; cur.ov_base = 32'h1FF; cur.ov_bytes = 32'h4433_2211;
    cur.pin_v = 1; cur.pin = 32'h4433_2211;                                prog.push_back(cur);
    cur = mk(6'b000000, 3'b001, 32'h0, 32'h5, 5'd0);                       prog.push_back(cur);
    cur = mk(6'b000000, 3'b101, 32'h0, 32'h1004, 5'd1);
    cur.pin_v = 1; cur.pin = 32'h0000_1004;                                prog.push_back(cur);
    cur = mk(6'b000000, 3'b010, 32'h300, 32'h0000_00A5, 5'd0);             prog.push_back(cur);
    cur = mk(6'b000001, 3'b011, 32'h301, 32'h0, 5'd9);                     prog.push_back(cur);
    cur = mk(6'b000001, 3'b010, 32'hFFFF_FFFF, 32'h0000_1234, 5'd0);       prog.push_back(cur);
    cur = mk(6'b000101, 3'b011, 32'hFFFF_FFFF, 32'h0, 5'd10);              prog.push_back(cur);
    cur = mk(6'b000000, 3'b000, 32'h0, 32'h77, 5'd3);                      prog.push_back(cur);
    cur = mk(6'b000000, 3'b100, 32'h0, 32'h88, 5'd4);                      prog.push_back(cur);

    // Reset asserted through the first two edges.
    e_rst[1] = 1'b1;
    e_rst[2] = 1'b1;
    step();
    step();
    rst = 1'b0;
    next_free = cyc;

    // Directed sequence; while busy, EX/MEM holds the next instruction on the inputs.
    while (prog.size() > 0) begin
      if (cyc >= next_free) begin
        cur = prog.pop_front();
        drive(cur);
        schedule(cur, cyc, next_free);
      end else begin
        drive(prog[0]);
      end
      step();
    end

    // Reset held for three cycles in the middle of a word load.
    while (cyc < next_free) begin garbage(); step(); end
    cur = mk(6'b000010, 3'b011, 32'h400, 32'h0, 5'd12);
    drive(cur);
    schedule(cur, cyc, next_free);
    step();
    garbage();
    step();
    rst = 1'b1;
    repeat (3) begin
      clear_after(cyc);
      e_rst[cyc+1] = 1'b1;
      step();
    end
    rst = 1'b0;
    next_free = cyc;

    // Random traffic; inputs are scrambled whenever the stage is busy.
    for (int n = 0; n < 400 && cyc < NCYC - 40; n++) begin
      while (cyc < next_free) begin garbage(); step(); end
      cur = rnd_ins();
      drive(cur);
      schedule(cur, cyc, next_free);
      step();
    end
    while (cyc < next_free) begin garbage(); step(); end
    drive(mk(6'b000000, 3'b000, 32'h0, 32'h0, 5'd0));
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
